// File: rtl/variable_pkg.sv
// Shared 1024x768@60 timing constants and the decoder's state type.
// Used by the generator side and by vga_timing_decoder / vga_pos_counter.
package variable_pkg;

   localparam int HOR_TOTAL_TIME  = 1344;
   localparam int HOR_BLANK_START = 1024;
   localparam int HOR_BLANK_END   = 1344;
   localparam int HOR_SYNC_START  = 1048;
   localparam int HOR_SYNC_TIME   = 136;

   localparam int VER_TOTAL_TIME  = 806;
   localparam int VER_BLANK_START = 768;
   localparam int VER_BLANK_END   = 806;
   localparam int VER_SYNC_START  = 771;
   localparam int VER_SYNC_TIME   = 6;

   localparam int HOR_TOTAL = HOR_BLANK_END;
   localparam int VER_TOTAL = VER_BLANK_END;

   typedef enum logic [1:0] {SEARCH, H_ALIGN, LOCKED} vga_dec_state_t;

endpackage

// File: rtl/vga_pos_counter.sv
// Recovered raster position counter.
//   h_clr / v_clr : load zero (takes priority over enable)
//   h_en          : advance h, wrapping at H_TOTAL
//   v_en          : advance v on the h wrap, wrapping at V_TOTAL
//   h_cur / v_cur : registered position
//   h_nxt / v_nxt : position one pixel after h_cur/v_cur (the expected
//                   position of the sample being taken this cycle)
module vga_pos_counter #(
   parameter int H_TOTAL = 1344,
   parameter int V_TOTAL = 806,
   parameter int CNT_W   = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             h_clr,
   input  logic             h_en,
   input  logic             v_clr,
   input  logic             v_en,
   output logic [CNT_W-1:0] h_cur,
   output logic [CNT_W-1:0] v_cur,
   output logic [CNT_W-1:0] h_nxt,
   output logic [CNT_W-1:0] v_nxt
);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;
   logic             h_wrap;

   always_comb begin
      h_wrap = (h_q == H_LAST);
      h_nxt  = h_wrap ? '0 : h_q + CNT_W'(1);
      v_nxt  = v_q;
      if (h_wrap) begin
         v_nxt = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
      end

      h_d = h_q;
      if (h_clr) begin
         h_d = '0;
      end else if (h_en) begin
         h_d = h_nxt;
      end

      v_d = v_q;
      if (v_clr) begin
         v_d = '0;
      end else if (v_en) begin
         v_d = v_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign h_cur = h_q;
   assign v_cur = v_q;

endmodule

// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing monitor: locks onto an hsync/vsync/hblnk/vblnk
// bus, regenerates hcount/vcount and checks every sample against the
// 1024x768@60 timing.
//   clk, rst_n                     : pixel clock, async active-low reset
//   hsync_in/vsync_in/hblnk_in/vblnk_in : incoming timing bus
//   hcount_out/vcount_out          : recovered position (0 when not tracked)
//   locked / h_locked              : full lock / horizontal lock
//   frame_start                    : pulse at (0,0) while locked
//   err_pulse / err_cnt            : mismatch pulse and saturating count
//
// state   | meaning
// --------+-----------------------------------------------------------
// SEARCH  | no tracking; waiting for a falling hblnk edge
// H_ALIGN | h tracked, hblnk/hsync checked; waiting for a frame start
// LOCKED  | h and v tracked, all four bus signals checked
module vga_timing_decoder
   import variable_pkg::*;
#(
   parameter int HOR_TOTAL = variable_pkg::HOR_TOTAL,
   parameter int VER_TOTAL = variable_pkg::VER_TOTAL,
   parameter int CNT_W     = 11,
   parameter int ERR_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             hblnk_in,
   input  logic             vblnk_in,
   output logic [CNT_W-1:0] hcount_out,
   output logic [CNT_W-1:0] vcount_out,
   output logic             locked,
   output logic             h_locked,
   output logic             frame_start,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [CNT_W-1:0] HB_START = CNT_W'(HOR_BLANK_START);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(HOR_SYNC_START);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(HOR_SYNC_START + HOR_SYNC_TIME);
   localparam logic [CNT_W-1:0] VB_START = CNT_W'(VER_BLANK_START);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(VER_SYNC_START);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(VER_SYNC_START + VER_SYNC_TIME);

   vga_dec_state_t   state_q, state_d;
   logic             prev_hblnk_q, prev_vblnk_q;
   logic             frame_start_q, frame_start_d;
   logic             err_pulse_q, err_pulse_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic             h_edge, v_edge;
   logic             h_clr, h_en, v_clr, v_en;
   logic             h_mis, v_mis, mismatch;
   logic [CNT_W-1:0] h_cur, v_cur, h_nxt, v_nxt;

   vga_pos_counter #(
      .H_TOTAL (HOR_TOTAL),
      .V_TOTAL (VER_TOTAL),
      .CNT_W   (CNT_W)
   ) u_pos (
      .clk   (clk),
      .rst_n (rst_n),
      .h_clr (h_clr),
      .h_en  (h_en),
      .v_clr (v_clr),
      .v_en  (v_en),
      .h_cur (h_cur),
      .v_cur (v_cur),
      .h_nxt (h_nxt),
      .v_nxt (v_nxt)
   );

   always_comb begin
      h_edge = prev_hblnk_q & ~hblnk_in;
      v_edge = prev_vblnk_q & ~vblnk_in;

      // Expected bus values for the position this sample should occupy.
      h_mis = (hblnk_in != (h_nxt >= HB_START)) |
              (hsync_in != ((h_nxt >= HS_START) && (h_nxt < HS_END)));
      v_mis = (vblnk_in != (v_nxt >= VB_START)) |
              (vsync_in != ((v_nxt >= VS_START) && (v_nxt < VS_END)));

      // Default: counters held at zero, which is also the clear on mismatch.
      state_d  = state_q;
      h_clr    = 1'b1;
      h_en     = 1'b0;
      v_clr    = 1'b1;
      v_en     = 1'b0;
      mismatch = 1'b0;

      case (state_q)
         SEARCH: begin
            if (h_edge) begin
               state_d = v_edge ? LOCKED : H_ALIGN;
            end
         end
         H_ALIGN: begin
            if (h_mis) begin
               mismatch = 1'b1;
               state_d  = SEARCH;
            end else begin
               h_clr = 1'b0;
               h_en  = 1'b1;
               if (h_edge && v_edge) begin
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (h_mis || v_mis) begin
               mismatch = 1'b1;
               state_d  = SEARCH;
            end else begin
               h_clr = 1'b0;
               h_en  = 1'b1;
               v_clr = 1'b0;
               v_en  = 1'b1;
            end
         end
         default: state_d = SEARCH;
      endcase

      frame_start_d = (state_d == LOCKED) &&
                      (h_clr || (h_nxt == '0)) &&
                      (v_clr || (v_nxt == '0));
      err_pulse_d   = mismatch;
      err_cnt_d     = err_cnt_q;
      if (mismatch && (err_cnt_q != {ERR_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= SEARCH;
         prev_hblnk_q  <= 1'b0;
         prev_vblnk_q  <= 1'b0;
         frame_start_q <= 1'b0;
         err_pulse_q   <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         prev_hblnk_q  <= hblnk_in;
         prev_vblnk_q  <= vblnk_in;
         frame_start_q <= frame_start_d;
         err_pulse_q   <= err_pulse_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   // Counters are forced to zero outside their tracking states, so the
   // registered counts can drive the outputs directly.
   assign hcount_out  = h_cur;
   assign vcount_out  = v_cur;
   assign locked      = (state_q == LOCKED);
   assign h_locked    = (state_q != SEARCH);
   assign frame_start = frame_start_q;
   assign err_pulse   = err_pulse_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Testbench for vga_timing_decoder: bench-side timing generator, reference
// model feeding a scoreboard queue, plus per-scenario inline checks.
module tb_vga_timing_decoder;

   localparam int CNT_W = 11;
   localparam int ERR_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [CNT_W-1:0] hcount_out, vcount_out;
   logic             locked, h_locked, frame_start, err_pulse;
   logic [ERR_W-1:0] err_cnt;

   vga_timing_decoder #(
      .HOR_TOTAL (1344),
      .VER_TOTAL (806),
      .CNT_W     (CNT_W),
      .ERR_W     (ERR_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .hblnk_in    (hblnk_in),
      .vblnk_in    (vblnk_in),
      .hcount_out  (hcount_out),
      .vcount_out  (vcount_out),
      .locked      (locked),
      .h_locked    (h_locked),
      .frame_start (frame_start),
      .err_pulse   (err_pulse),
      .err_cnt     (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        lk;
      logic        hl;
      logic        fs;
      logic        ep;
      logic [7:0]  ec;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // reference model state: 0 search, 1 h-aligned, 2 locked
   int m_st = 0, m_h = 0, m_v = 0, m_ec = 0;
   bit m_phb = 0, m_pvb = 0, m_ep = 0;

   // bench generator position
   int gen_h = 0, gen_v = 0, line_len = 1344;

   task automatic model_reset();
      m_st = 0; m_h = 0; m_v = 0; m_ec = 0;
      m_phb = 0; m_pvb = 0; m_ep = 0;
   endtask

   task automatic model_step(input bit hs, input bit vs, input bit hb, input bit vb);
      bit he, ve, bad;
      int eh, ev;
      he = m_phb && !hb;
      ve = m_pvb && !vb;
      eh = (m_h == 1343) ? 0 : m_h + 1;
      ev = m_v;
      if (m_h == 1343) ev = (m_v == 805) ? 0 : m_v + 1;
      bad = 0;
      if (m_st == 0) begin
         if (he) begin
            m_h = 0;
            if (ve) begin m_v = 0; m_st = 2; end
            else m_st = 1;
         end
      end else begin
         if (hb != (eh >= 1024)) bad = 1;
         if (hs != (eh >= 1048 && eh < 1184)) bad = 1;
         if (m_st == 2) begin
            if (vb != (ev >= 768)) bad = 1;
            if (vs != (ev >= 771 && ev < 777)) bad = 1;
         end
         if (!bad) begin
            m_h = eh;
            if (m_st == 2) m_v = ev;
            else if (he && ve) begin m_v = 0; m_st = 2; end
         end
      end
      m_ep = bad;
      if (bad) begin
         m_st = 0; m_h = 0; m_v = 0;
         if (m_ec < 255) m_ec = m_ec + 1;
      end
      m_phb = hb;
      m_pvb = vb;
   endtask

   // Drive one sample, push its expected outputs, return just after the
   // edge that captured it.
   task automatic step(input bit hs, input bit vs, input bit hb, input bit vb);
      obs_t e;
      @(negedge clk);
      hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
      if (!rst_n) model_reset();
      else model_step(hs, vs, hb, vb);
      e.h  = (m_st != 0) ? 11'(m_h) : 11'd0;
      e.v  = (m_st == 2) ? 11'(m_v) : 11'd0;
      e.lk = (m_st == 2);
      e.hl = (m_st != 0);
      e.fs = (m_st == 2) && (m_h == 0) && (m_v == 0);
      e.ep = m_ep;
      e.ec = 8'(m_ec);
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic gen_sample(input bit flip_hs);
      bit hb, hs, vb, vs;
      hb = (gen_h >= 1024);
      hs = ((gen_h >= 1048) && (gen_h < 1184)) ^ flip_hs;
      vb = (gen_v >= 768);
      vs = (gen_v >= 771) && (gen_v < 777);
      step(hs, vs, hb, vb);
      gen_h = gen_h + 1;
      if (gen_h == line_len) begin
         gen_h = 0;
         gen_v = (gen_v == 805) ? 0 : gen_v + 1;
      end
   endtask

   // scoreboard: compare every captured sample one edge later
   initial begin
      obs_t e, got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {hcount_out, vcount_out, locked, h_locked, frame_start, err_pulse, err_cnt};
            checks++;
            if (got !== e) begin
               failures++;
               $display("FAIL scoreboard t=%0t got h=%0d v=%0d lk=%b hl=%b fs=%b ep=%b ec=%0d exp h=%0d v=%0d lk=%b hl=%b fs=%b ep=%b ec=%0d",
                        $time, got.h, got.v, got.lk, got.hl, got.fs, got.ep, got.ec,
                        e.h, e.v, e.lk, e.hl, e.fs, e.ep, e.ec);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (4) step(1'b1, 1'b0, 1'b1, 1'b1);
      checks++;
      if ({hcount_out, vcount_out, locked, h_locked, frame_start, err_pulse, err_cnt} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got h=%0d v=%0d lk=%b hl=%b ec=%0d exp all zero",
                  hcount_out, vcount_out, locked, h_locked, err_cnt);
      end
   endtask

   task automatic test_cold_start();
      int fs_cnt = 0;
      bit seen_lock = 0;
      gen_h = 0; gen_v = 804; line_len = 1344;
      rst_n = 1'b1;
      for (int i = 0; i < 16628; i++) begin
         gen_sample(1'b0);
         if (frame_start === 1'b1) fs_cnt++;
         if (i == 1344) begin
            checks++;
            if (h_locked !== 1'b1 || locked !== 1'b0 || hcount_out !== 11'd0) begin
               failures++;
               $display("FAIL cold_h_lock got hl=%b lk=%b h=%0d exp hl=1 lk=0 h=0", h_locked, locked, hcount_out);
            end
         end
         if (locked === 1'b1 && !seen_lock) begin
            seen_lock = 1;
            checks++;
            if (hcount_out !== 11'd0 || vcount_out !== 11'd0 || frame_start !== 1'b1) begin
               failures++;
               $display("FAIL cold_first_lock got h=%0d v=%0d fs=%b exp h=0 v=0 fs=1", hcount_out, vcount_out, frame_start);
            end
         end
      end
      checks++;
      if (!seen_lock) begin
         failures++;
         $display("FAIL cold_lock_seen got none exp locked within budget");
      end
      checks++;
      if (fs_cnt != 1) begin
         failures++;
         $display("FAIL cold_frame_start_count got %0d exp 1", fs_cnt);
      end
      checks++;
      if (err_cnt !== 8'd0 || locked !== 1'b1 || hcount_out !== 11'd499 || vcount_out !== 11'd10) begin
         failures++;
         $display("FAIL cold_tracking got ec=%0d lk=%b h=%0d v=%0d exp ec=0 lk=1 h=499 v=10",
                  err_cnt, locked, hcount_out, vcount_out);
      end
   endtask

   task automatic test_glitch();
      gen_sample(1'b1);
      checks++;
      if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0 || h_locked !== 1'b0 ||
          hcount_out !== 11'd0 || vcount_out !== 11'd0) begin
         failures++;
         $display("FAIL glitch_detect got ep=%b ec=%0d lk=%b hl=%b h=%0d v=%0d exp ep=1 ec=1 lk=0 hl=0 h=0 v=0",
                  err_pulse, err_cnt, locked, h_locked, hcount_out, vcount_out);
      end
      gen_sample(1'b0);
      checks++;
      if (err_pulse !== 1'b0) begin
         failures++;
         $display("FAIL glitch_pulse_width got ep=%b exp 0", err_pulse);
      end
      for (int i = 0; i < 842; i++) gen_sample(1'b0);
      checks++;
      if (h_locked !== 1'b0) begin
         failures++;
         $display("FAIL glitch_no_early_relock got hl=%b exp 0", h_locked);
      end
      gen_sample(1'b0);
      checks++;
      if (h_locked !== 1'b1 || hcount_out !== 11'd0 || locked !== 1'b0) begin
         failures++;
         $display("FAIL glitch_h_relock got hl=%b h=%0d lk=%b exp hl=1 h=0 lk=0", h_locked, hcount_out, locked);
      end
      for (int i = 0; i < 100; i++) gen_sample(1'b0);
      checks++;
      if (hcount_out !== 11'd100 || vcount_out !== 11'd0 || locked !== 1'b0) begin
         failures++;
         $display("FAIL glitch_h_track got h=%0d v=%0d lk=%b exp h=100 v=0 lk=0", hcount_out, vcount_out, locked);
      end
   endtask

   task automatic test_midframe_reset();
      bit any_lock = 0;
      bit early_hl = 0;
      rst_n = 1'b0;
      gen_h = 598; gen_v = 400;
      gen_sample(1'b0);
      gen_sample(1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 744; i++) begin
         gen_sample(1'b0);
         if (h_locked !== 1'b0) early_hl = 1;
      end
      checks++;
      if (early_hl) begin
         failures++;
         $display("FAIL midreset_early_hlock got hl=1 before line start exp 0");
      end
      gen_sample(1'b0);
      checks++;
      if (h_locked !== 1'b1 || hcount_out !== 11'd0 || err_cnt !== 8'd0) begin
         failures++;
         $display("FAIL midreset_h_lock got hl=%b h=%0d ec=%0d exp hl=1 h=0 ec=0", h_locked, hcount_out, err_cnt);
      end
      for (int i = 0; i < 1343; i++) begin
         gen_sample(1'b0);
         if (locked !== 1'b0) any_lock = 1;
      end
      checks++;
      if (any_lock || hcount_out !== 11'd1343 || vcount_out !== 11'd0) begin
         failures++;
         $display("FAIL midreset_track got anylock=%b h=%0d v=%0d exp anylock=0 h=1343 v=0",
                  any_lock, hcount_out, vcount_out);
      end
   endtask

   task automatic test_stretched();
      int pulses = 0;
      bit any_lock = 0;
      rst_n = 1'b0;
      gen_sample(1'b0);
      line_len = 1345;
      gen_h = 0; gen_v = 100;
      rst_n = 1'b1;
      for (int i = 0; i < 20 * 1345; i++) begin
         gen_sample(1'b0);
         if (err_pulse === 1'b1) pulses++;
         if (locked !== 1'b0) any_lock = 1;
      end
      checks++;
      if (pulses != 19 || err_cnt !== 8'd19 || any_lock) begin
         failures++;
         $display("FAIL stretched_lines got pulses=%0d ec=%0d anylock=%b exp pulses=19 ec=19 anylock=0",
                  pulses, err_cnt, any_lock);
      end
      line_len = 1344;
   endtask

   task automatic test_saturate();
      bit any_lock = 0;
      bit late_pulse = 0;
      for (int i = 0; i < 600; i++) begin
         step(1'b0, 1'b0, (i % 2 == 0), 1'b0);
         if (locked !== 1'b0) any_lock = 1;
         if (i >= 590 && err_pulse === 1'b1) late_pulse = 1;
      end
      checks++;
      if (err_cnt !== 8'd255 || any_lock || !late_pulse) begin
         failures++;
         $display("FAIL saturate got ec=%0d anylock=%b late_pulse=%b exp ec=255 anylock=0 late_pulse=1",
                  err_cnt, any_lock, late_pulse);
      end
   endtask

   task automatic test_reset_pulse();
      gen_h = 1000; gen_v = 805; line_len = 1344;
      for (int i = 0; i < 344; i++) gen_sample(1'b0);
      gen_sample(1'b0);
      checks++;
      if (locked !== 1'b1 || frame_start !== 1'b1 || err_cnt !== 8'd255) begin
         failures++;
         $display("FAIL pulse_prelock got lk=%b fs=%b ec=%0d exp lk=1 fs=1 ec=255", locked, frame_start, err_cnt);
      end
      for (int i = 0; i < 1344 + 699; i++) gen_sample(1'b0);
      checks++;
      if (locked !== 1'b1 || hcount_out !== 11'd699 || vcount_out !== 11'd1) begin
         failures++;
         $display("FAIL pulse_locked_before got lk=%b h=%0d v=%0d exp lk=1 h=699 v=1", locked, hcount_out, vcount_out);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (locked !== 1'b0 || err_cnt !== 8'd0 || hcount_out !== 11'd0) begin
         failures++;
         $display("FAIL pulse_async_clear got lk=%b ec=%0d h=%0d exp 0 0 0", locked, err_cnt, hcount_out);
      end
      for (int i = 0; i < 3; i++) begin
         gen_sample(1'b0);
         checks++;
         if ({hcount_out, vcount_out, locked, h_locked, frame_start, err_pulse, err_cnt} !== '0) begin
            failures++;
            $display("FAIL pulse_in_reset got h=%0d v=%0d lk=%b hl=%b ec=%0d exp all zero",
                     hcount_out, vcount_out, locked, h_locked, err_cnt);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 641; i++) gen_sample(1'b0);
      checks++;
      if (h_locked !== 1'b0 || locked !== 1'b0) begin
         failures++;
         $display("FAIL pulse_no_early_lock got hl=%b lk=%b exp 0 0", h_locked, locked);
      end
      gen_sample(1'b0);
      checks++;
      if (h_locked !== 1'b1 || hcount_out !== 11'd0 || locked !== 1'b0 || err_cnt !== 8'd0) begin
         failures++;
         $display("FAIL pulse_relock got hl=%b h=%0d lk=%b ec=%0d exp hl=1 h=0 lk=0 ec=0",
                  h_locked, hcount_out, locked, err_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_cold_start();
      test_glitch();
      test_midframe_reset();
      test_stretched();
      test_saturate();
      test_reset_pulse();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
